// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO burst streamer read-side drain engine.
package fifo_stream_pkg;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  localparam int unsigned BUF_DEPTH = 3;
  localparam int unsigned PKT_CNT_W = 16;

  // Room for one more read: buffered beats plus the in-flight read must stay below BUF_DEPTH.
  function automatic logic can_pop(input logic [1:0] occ, input logic pend);
    return ({1'b0, occ} + {2'b0, pend}) < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/stream_out_buf.sv
// 3-entry synchronous circular buffer holding {last, data} beats between the FIFO read port and the stream output.
module stream_out_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             push_last,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             last,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       occ
);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t     mem [BUF_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] count;
  logic       push_ok;
  logic       pop_ok;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign pop_ok  = pop && (count != 2'd0);
  // A push into a full buffer is still legal when the head leaves in the same cycle.
  assign push_ok = push && ((count != 2'(BUF_DEPTH)) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= '{last: push_last, data: push_data};
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign last  = mem[rd_ptr].last;
  assign data  = mem[rd_ptr].data;
  assign occ   = count;

endmodule

// File: rtl/fifo_burst_streamer.sv
// Drains a registered-output FIFO in whole BURST_LEN bursts onto a valid/ready stream with m_last per burst.
// Optional macro FIFO_STREAM_PKT_CNT_EN adds the pkt_count output counting completed packets.
module fifo_burst_streamer
  import fifo_stream_pkg::*;
#(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned BURST_LEN  = 8,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enable,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
`ifdef FIFO_STREAM_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0] pkt_count
`endif
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] pop_cnt;
  logic             pend;
  logic             pend_last;
  logic             last_pop;
  logic [1:0]       occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= S_IDLE;
    else if (flush) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Every input here is registered, so fifo_pop has no path from m_ready.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    last_pop  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (fifo_level >= LVL_W'(BURST_LEN))) state_nxt = S_BURST;
      end
      S_BURST: begin
        fifo_pop = can_pop(occ, pend);
        last_pop = fifo_pop && (pop_cnt == CNT_W'(BURST_LEN - 1));
        if (last_pop) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_cnt   <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else if (flush) begin
      pop_cnt   <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      pend      <= fifo_pop;
      pend_last <= last_pop;
      if (state == S_IDLE) pop_cnt <= '0;
      else if (fifo_pop)   pop_cnt <= pop_cnt + 1'b1;
    end
  end

  stream_out_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (pend),
    .push_last(pend_last),
    .push_data(fifo_data),
    .pop      (m_ready),
    .valid    (m_valid),
    .last     (m_last),
    .data     (m_data),
    .occ      (occ)
  );

  assign busy = (state == S_BURST) || pend || (occ != 2'd0);

`ifdef FIFO_STREAM_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             pkt_count <= '0;
    else if (flush)                         pkt_count <= '0;
    else if (m_valid && m_ready && m_last)  pkt_count <= pkt_count + 1'b1;
  end
`endif

endmodule
